// File: rtl/text_lcd_driver.sv
// Write-only HD44780 16x2 driver: power-up wait, init commands, then continuous two-line refresh.
// Optional LCD_SKIP_UNCHANGED_EN: sit idle instead of rewriting a snapshot identical to the last frame.
module text_lcd_driver #(
    parameter int unsigned POWERUP_CYC = 15000,
    parameter int unsigned E_PULSE_CYC = 2,
    parameter int unsigned CMD_CYC     = 50,
    parameter int unsigned CLEAR_CYC   = 2000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] line1_data,
    input  logic [127:0] line2_data,
    output logic         lcd_e,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic [7:0]   lcd_data,
    output logic         init_done,
    output logic         frame_done
);
    localparam int unsigned MaxA   = (POWERUP_CYC > E_PULSE_CYC) ? POWERUP_CYC : E_PULSE_CYC;
    localparam int unsigned MaxB   = (CMD_CYC > CLEAR_CYC) ? CMD_CYC : CLEAR_CYC;
    localparam int unsigned MaxCyc = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);

    localparam logic [CntW-1:0] PwrLast   = CntW'(POWERUP_CYC - 1);
    localparam logic [CntW-1:0] EhiLast   = CntW'(E_PULSE_CYC - 1);
    localparam logic [CntW-1:0] CmdLast   = CntW'(CMD_CYC - 1);
    localparam logic [CntW-1:0] ClearLast = CntW'(CLEAR_CYC - 1);

    typedef enum logic [2:0] {
        StPwrup, StInit, StAddr1, StChar1, StAddr2, StChar2, StIdle
    } state_e;
    typedef enum logic [1:0] {PhSetup, PhEHigh, PhWait} phase_e;

    state_e          st_q, nxt_st;
    phase_e          ph_q;
    logic [CntW-1:0] cnt_q, wait_last;
    logic [3:0]      idx_q, nxt_idx;
    logic [127:0]    shadow1_q, shadow2_q;
    logic [8:0]      nxt_word;

    assign lcd_rw = 1'b0;

    // Successor of the current write and the {rs, data} word it will present in SETUP.
    always_comb begin
        wait_last = (st_q == StInit && idx_q == 4'd3) ? ClearLast : CmdLast;
        nxt_st    = st_q;
        nxt_idx   = idx_q + 4'd1;
        case (st_q)
            StInit: if (idx_q == 4'd3) begin
                nxt_st  = StAddr1;
                nxt_idx = '0;
            end
            StAddr1: begin
                nxt_st  = StChar1;
                nxt_idx = '0;
            end
            StChar1: if (idx_q == 4'd15) begin
                nxt_st  = StAddr2;
                nxt_idx = '0;
            end
            StAddr2: begin
                nxt_st  = StChar2;
                nxt_idx = '0;
            end
            StChar2: if (idx_q == 4'd15) begin
                nxt_st  = StAddr1;
                nxt_idx = '0;
`ifdef LCD_SKIP_UNCHANGED_EN
                if ({line1_data, line2_data} == {shadow1_q, shadow2_q}) nxt_st = StIdle;
`endif
            end
            default: ;
        endcase

        nxt_word = {lcd_rs, lcd_data};
        case (nxt_st)
            StInit: begin
                case (nxt_idx[1:0])
                    2'd0:    nxt_word = 9'h038;
                    2'd1:    nxt_word = 9'h00C;
                    2'd2:    nxt_word = 9'h006;
                    default: nxt_word = 9'h001;
                endcase
            end
            StAddr1: nxt_word = 9'h080;
            StChar1: nxt_word = {1'b1, shadow1_q[{nxt_idx, 3'b000} +: 8]};
            StAddr2: nxt_word = 9'h0C0;
            StChar2: nxt_word = {1'b1, shadow2_q[{nxt_idx, 3'b000} +: 8]};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= StPwrup;
            ph_q       <= PhSetup;
            cnt_q      <= '0;
            idx_q      <= '0;
            shadow1_q  <= '0;
            shadow2_q  <= '0;
            lcd_e      <= 1'b0;
            lcd_rs     <= 1'b0;
            lcd_data   <= 8'h00;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (st_q)
                StPwrup: begin
                    if (cnt_q == PwrLast) begin
                        st_q               <= StInit;
                        idx_q              <= '0;
                        ph_q               <= PhSetup;
                        cnt_q              <= '0;
                        {lcd_rs, lcd_data} <= 9'h038;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`ifdef LCD_SKIP_UNCHANGED_EN
                StIdle: begin
                    if ({line1_data, line2_data} != {shadow1_q, shadow2_q}) begin
                        st_q               <= StAddr1;
                        idx_q              <= '0;
                        ph_q               <= PhSetup;
                        cnt_q              <= '0;
                        shadow1_q          <= line1_data;
                        shadow2_q          <= line2_data;
                        {lcd_rs, lcd_data} <= 9'h080;
                    end
                end
`endif
                default: begin
                    case (ph_q)
                        PhSetup: begin
                            ph_q  <= PhEHigh;
                            cnt_q <= '0;
                            lcd_e <= 1'b1;
                        end
                        PhEHigh: begin
                            if (cnt_q == EhiLast) begin
                                ph_q  <= PhWait;
                                cnt_q <= '0;
                                lcd_e <= 1'b0;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        default: begin
                            if (cnt_q == wait_last) begin
                                ph_q               <= PhSetup;
                                cnt_q              <= '0;
                                st_q               <= nxt_st;
                                idx_q              <= nxt_idx;
                                {lcd_rs, lcd_data} <= nxt_word;
                                if (st_q == StInit && idx_q == 4'd3) init_done <= 1'b1;
                                if (st_q == StChar2 && idx_q == 4'd15) frame_done <= 1'b1;
                                // Snapshot is taken only on the edge that enters ADDR1.
                                if (nxt_st == StAddr1) begin
                                    shadow1_q <= line1_data;
                                    shadow2_q <= line2_data;
                                end
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    endcase
                end
            endcase
        end
    end
endmodule

// File: tb/tb_text_lcd_driver.sv
// Self-checking bench for text_lcd_driver: timing table, bus scoreboard, reset abort.
// Define LCD_SKIP_UNCHANGED_EN to also exercise the skip-unchanged behaviour.
module tb_text_lcd_driver;
    localparam int unsigned PwrCyc   = 10;
    localparam int unsigned EPulse   = 2;
    localparam int unsigned CmdCyc   = 4;
    localparam int unsigned ClearCyc = 8;
    localparam int          FrameCyc = 34 * (1 + EPulse + CmdCyc);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] line1, line2;
    logic         lcd_e, lcd_rs, lcd_rw, init_done, frame_done;
    logic [7:0]   lcd_data;

    int total = 0;
    int bad   = 0;

    text_lcd_driver #(
        .POWERUP_CYC(PwrCyc),
        .E_PULSE_CYC(EPulse),
        .CMD_CYC    (CmdCyc),
        .CLEAR_CYC  (ClearCyc)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .line1_data(line1),
        .line2_data(line2),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_data  (lcd_data),
        .init_done (init_done),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] pack(input string s);
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[8*k +: 8] = s[k];
        return v;
    endfunction

    // What the DUT saw at each edge.
    int           cyc = 0;
    logic         rst_seen;
    logic [127:0] snap1, snap2;
    always @(posedge clk) begin
        rst_seen <= rst;
        snap1    <= line1;
        snap2    <= line2;
        cyc      <= rst ? 0 : cyc + 1;
    end

    // Scoreboard: expected write stream derived from the snapshot at each ADDR1 entry.
    logic [8:0] expq[$];
    logic [8:0] prev_bus, last_w, w;
    logic       prev_e;
    int         fr_cnt = 0, fw_cnt = 0, fd_cnt = 0, rise_cnt = 0, last_fd = 0;

    always @(negedge clk) begin
        if (rst_seen !== 1'b0) begin
            expq.delete();
            expq.push_back(9'h038);
            expq.push_back(9'h00C);
            expq.push_back(9'h006);
            expq.push_back(9'h001);
            fw_cnt   = 0;
            fd_cnt   = 0;
            last_fd  = 0;
            prev_e   = 1'b0;
            prev_bus = '0;
        end else begin
            chk("rw_low", {31'd0, lcd_rw}, 0);
            if (prev_e) chk("bus_stable", {23'd0, lcd_rs, lcd_data}, {23'd0, prev_bus});
            if ({lcd_e, lcd_rs, lcd_data} == 10'h080 && prev_bus != 9'h080) begin
                chk("prev_frame_complete", expq.size(), 0);
                expq.delete();
                expq.push_back(9'h080);
                for (int k = 0; k < 16; k++) expq.push_back({1'b1, snap1[8*k +: 8]});
                expq.push_back(9'h0C0);
                for (int k = 0; k < 16; k++) expq.push_back({1'b1, snap2[8*k +: 8]});
                fr_cnt++;
                fw_cnt = 0;
            end
            if (lcd_e && !prev_e) begin
                if (expq.size() == 0) begin
                    chk("unexpected_write", {23'd0, lcd_rs, lcd_data}, 32'hFFFF);
                end else begin
                    w = expq.pop_front();
                    chk("write_word", {23'd0, lcd_rs, lcd_data}, {23'd0, w});
                end
                fw_cnt++;
                rise_cnt++;
                last_w = {lcd_rs, lcd_data};
            end
            if (frame_done) begin
                fd_cnt++;
`ifndef LCD_SKIP_UNCHANGED_EN
                if (last_fd != 0) chk("frame_period", cyc - last_fd, FrameCyc);
                chk("fd_at_addr1", {22'd0, lcd_e, lcd_rs, lcd_data}, 32'h080);
`endif
                last_fd = cyc;
            end
            prev_e   = lcd_e;
            prev_bus = {lcd_rs, lcd_data};
        end
    end

    typedef struct {
        int         c;
        logic       e;
        logic       rs;
        logic [7:0] d;
        logic       init;
        logic       fd;
    } vec_t;

    initial begin
        string      s1 = "  2024.05.17    ";
        string      s2 = "  AM 09:30:00   ";
        vec_t       vecs[$];
        logic [7:0] b;
        int         id, r0, fr0, col;

        line1 = pack(s1);
        line2 = pack(s2);
        rst   = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        vecs.push_back('{0,   1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{9,   1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{10,  1'b0, 1'b0, 8'h38, 1'b0, 1'b0});
        vecs.push_back('{11,  1'b1, 1'b0, 8'h38, 1'b0, 1'b0});
        vecs.push_back('{13,  1'b0, 1'b0, 8'h38, 1'b0, 1'b0});
        vecs.push_back('{17,  1'b0, 1'b0, 8'h0C, 1'b0, 1'b0});
        vecs.push_back('{24,  1'b0, 1'b0, 8'h06, 1'b0, 1'b0});
        vecs.push_back('{31,  1'b0, 1'b0, 8'h01, 1'b0, 1'b0});
        vecs.push_back('{33,  1'b1, 1'b0, 8'h01, 1'b0, 1'b0});
        vecs.push_back('{34,  1'b0, 1'b0, 8'h01, 1'b0, 1'b0});
        vecs.push_back('{41,  1'b0, 1'b0, 8'h01, 1'b0, 1'b0});
        vecs.push_back('{42,  1'b0, 1'b0, 8'h80, 1'b1, 1'b0});
        vecs.push_back('{49,  1'b0, 1'b1, line1[7:0], 1'b1, 1'b0});
        vecs.push_back('{50,  1'b1, 1'b1, line1[7:0], 1'b1, 1'b0});
        vecs.push_back('{70,  1'b0, 1'b1, line1[31:24], 1'b1, 1'b0});
        vecs.push_back('{161, 1'b0, 1'b0, 8'hC0, 1'b1, 1'b0});
        vecs.push_back('{168, 1'b0, 1'b1, line2[7:0], 1'b1, 1'b0});
        vecs.push_back('{279, 1'b0, 1'b1, line2[127:120], 1'b1, 1'b0});
`ifdef LCD_SKIP_UNCHANGED_EN
        vecs.push_back('{280, 1'b0, 1'b1, line2[127:120], 1'b1, 1'b1});
        vecs.push_back('{281, 1'b0, 1'b1, line2[127:120], 1'b1, 1'b0});
`else
        vecs.push_back('{280, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1});
        vecs.push_back('{281, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0});
`endif

        foreach (vecs[i]) begin
            for (int g = 0; g < 400 && cyc < vecs[i].c; g++) @(negedge clk);
            chk($sformatf("vec_reach_c%0d", vecs[i].c), cyc, vecs[i].c);
            chk($sformatf("vec_c%0d", vecs[i].c),
                {20'd0, lcd_e, lcd_rs, lcd_data, init_done, frame_done},
                {20'd0, vecs[i].e, vecs[i].rs, vecs[i].d, vecs[i].init, vecs[i].fd});
        end

`ifdef LCD_SKIP_UNCHANGED_EN
        r0 = rise_cnt;
        repeat (600) @(negedge clk);
        chk("skip_single_fd", fd_cnt, 1);
        chk("skip_no_e_activity", rise_cnt - r0, 0);
        line2[127:120] = line2[127:120] ^ 8'h41;
        r0 = rise_cnt;
        repeat (600) @(negedge clk);
        chk("skip_change_fd", fd_cnt, 2);
        chk("skip_change_writes", rise_cnt - r0, 34);
`endif

        // Mid-frame change: current frame keeps the old byte, next frame carries the new one.
        line2[7:0] = line2[7:0] ^ 8'h01;
        for (int g = 0; g < 1000 && fw_cnt != 20; g++) @(negedge clk);
        chk("midframe_reach", fw_cnt, 20);
        id = fr_cnt;
        b  = line1[31:24] ^ 8'h5A;
        line1[31:24] = b;
        for (int g = 0; g < 1000 && !(fr_cnt == id + 1 && fw_cnt == 5); g++) @(negedge clk);
        chk("next_frame_col3", {23'd0, last_w}, {23'd1, b});

        fr0 = fr_cnt;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 24) == 0) begin
                col = $urandom_range(0, 15);
                b   = 8'($urandom);
                if ($urandom_range(0, 1) == 1) line1[8*col +: 8] = b;
                else line2[8*col +: 8] = b;
            end
        end
        chk("random_frames_seen", {31'd0, (fr_cnt - fr0) >= 5}, 1);

        // Reset while e is high during CHAR1.
        line1[7:0] = line1[7:0] ^ 8'h10;
        for (int g = 0; g < 2000 && !(fw_cnt >= 3 && fw_cnt <= 17 && lcd_e); g++)
            @(negedge clk);
        chk("rst_hit_char1_e", {31'd0, lcd_e}, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_abort", {20'd0, lcd_e, lcd_rs, lcd_data, init_done, frame_done}, 0);
        rst = 1'b0;
        for (int g = 0; g < 100 && !init_done; g++) @(negedge clk);
        chk("reinit_cycle", cyc, 42);
        for (int g = 0; g < 600 && fd_cnt == 0; g++) @(negedge clk);
        chk("post_reset_frame", fd_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
